// File: rtl/rng_share_arbiter_pkg.sv
// Shared types and constants for the rng_share_arbiter random-source block.
package rng_pkg;

    localparam int LFSR_W = 23;
    localparam int WORD_W = 8;
    localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 23'h1;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        WARMUP = 2'd1,
        SERVE  = 2'd2
    } rng_state_e;

    // An all-zero Fibonacci LFSR never leaves zero, so swap in a live seed.
    function automatic logic [LFSR_W-1:0] seed_guard(input logic [LFSR_W-1:0] v);
        return (v == '0) ? ZERO_SEED_SUB : v;
    endfunction

endpackage

// File: rtl/rng_share_arbiter_if.sv
// Requester-side bus of the shared random source: seed/reseed/req in, word + owner out.
interface rng_share_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import rng_pkg::*;

    logic [LFSR_W-1:0]  seed;
    logic               reseed;
    logic [NUM_REQ-1:0] req;
    logic [WORD_W-1:0]  rnd_data;
    logic [NUM_REQ-1:0] rnd_vld;
    logic               rng_ready;

    modport master (
        output seed, reseed, req,
        input  rnd_data, rnd_vld, rng_ready
    );

    modport slave (
        input  seed, reseed, req,
        output rnd_data, rnd_vld, rng_ready
    );

endinterface

// File: rtl/rng_share_arbiter_lfsr.sv
// 23-bit Fibonacci LFSR holding register plus its combinational 8-bit output word.
module rng_lfsr23_step
    import rng_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              step,
    output logic [LFSR_W-1:0] state,
    output logic [WORD_W-1:0] w
);

    logic [LFSR_W-1:0] s_q;

    always_comb begin
        w    = '0;
        w[7] = s_q[22] ^ s_q[1];
        w[6] = s_q[21] ^ s_q[0];
        w[5] = s_q[20] ^ w[7];
        w[4] = s_q[19] ^ w[6];
        w[3] = s_q[18] ^ w[5];
        w[2] = s_q[17] ^ w[4];
        w[1] = s_q[16] ^ w[3];
        w[0] = s_q[15] ^ w[2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q <= '0;
        end else if (load) begin
            s_q <= load_val;
        end else if (step) begin
            s_q <= {s_q[LFSR_W-2:0], w[7]};
        end
    end

    assign state = s_q;

endmodule

// File: rtl/rng_share_arbiter.sv
// One LFSR shared round-robin between NUM_REQ workers: seed, warm-up discard, serve.
// Optional draw counter output enabled with `define RNG_DRAW_COUNT_EN.
module rng_share_arbiter
    import rng_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WARMUP  = 0
) (
    input  logic        clk,
    input  logic        rst,
    rng_share_arbiter_if.slave bus
`ifdef RNG_DRAW_COUNT_EN
    ,
    output logic [31:0] draw_cnt
`endif
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [1:0] ST_SEED   = SEED;
    localparam logic [1:0] ST_WARMUP = WARMUP_ST_VAL();
    localparam logic [1:0] ST_SERVE  = SERVE;
    localparam logic [7:0] WARM_LAST = (WARMUP > 0) ? 8'(WARMUP - 1) : 8'd0;

    function automatic logic [1:0] WARMUP_ST_VAL();
        return rng_pkg::WARMUP;
    endfunction

    logic [1:0]         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [7:0]         wcnt_q, wcnt_d;
    logic [WORD_W-1:0]  data_q, data_d;
    logic [NUM_REQ-1:0] vld_q, vld_d;

    logic [LFSR_W-1:0]  lfsr_s;
    logic [WORD_W-1:0]  lfsr_w;
    logic               found;
    logic [PTR_W-1:0]   win;
    logic               grant;
    logic               warm_step;

    rng_lfsr23_step u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (state_q == ST_SEED),
        .load_val (seed_guard(bus.seed)),
        .step     (grant || warm_step),
        .state    (lfsr_s),
        .w        (lfsr_w)
    );

    // Round-robin search: first requester at or after ptr, wrapping.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && bus.req[(int'(ptr_q) + i) % NUM_REQ]) begin
                found = 1'b1;
                win   = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
            end
        end
    end

    // A dead (all-zero) source never hands out a word; reseed beats any request.
    assign grant     = (state_q == ST_SERVE) && !bus.reseed && found && (|lfsr_s);
    assign warm_step = (state_q == ST_WARMUP) && !bus.reseed;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wcnt_d  = wcnt_q;
        data_d  = data_q;
        vld_d   = '0;
        if (bus.reseed) begin
            state_d = ST_SEED;
            wcnt_d  = '0;
        end else begin
            case (state_q)
                ST_SEED: begin
                    state_d = (WARMUP > 0) ? ST_WARMUP : ST_SERVE;
                    wcnt_d  = '0;
                end
                ST_WARMUP: begin
                    if (wcnt_q == WARM_LAST) begin
                        state_d = ST_SERVE;
                        wcnt_d  = '0;
                    end else begin
                        wcnt_d = wcnt_q + 8'd1;
                    end
                end
                ST_SERVE: begin
                    if (grant) begin
                        data_d = lfsr_w;
                        vld_d  = NUM_REQ'(1) << win;
                        ptr_d  = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
                    end
                end
                default: state_d = ST_SEED;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_SEED;
            ptr_q   <= '0;
            wcnt_q  <= '0;
            data_q  <= 8'hFF;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wcnt_q  <= wcnt_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.rnd_data  = data_q;
    assign bus.rnd_vld   = vld_q;
    assign bus.rng_ready = (state_q == ST_SERVE);

`ifdef RNG_DRAW_COUNT_EN
    logic [31:0] draw_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            draw_cnt_q <= '0;
        end else if (state_d == ST_SEED) begin
            draw_cnt_q <= '0;
        end else if (grant) begin
            draw_cnt_q <= draw_cnt_q + 32'd1;
        end
    end

    assign draw_cnt = draw_cnt_q;
`endif

endmodule

// File: doc/rng_share_arbiter.md
Name: rng_share_arbiter

Overview:
- Shares one 23-bit Fibonacci LFSR random source between NUM_REQ Monte Carlo path workers in the Hawkes simulator.
- Sequences the source through seed load, warm-up discard, then round-robin service of 8-bit random words, one word per cycle at most.
- Supports a runtime reseed.

Parameters:
- NUM_REQ, 4: number of requesters, 2..16.
- WARMUP, 0: LFSR steps discarded after every seed load, 0..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- seed  in  23  seed value, sampled in SEED state.
- reseed  in  1  single-cycle pulse; restarts the seed/warm-up sequence.
- req  in  NUM_REQ  per-requester draw request (level).
- rnd_data  out  8  granted random word, registered, shared by all requesters.
- rnd_vld  out  NUM_REQ  one-hot, one-cycle pulse marking the owner of rnd_data.
- rng_ready  out  1  high while in SERVE.

Behaviour:
- LFSR word from state s:
  - w7=s22^s1, w6=s21^s0, w5=s20^w7, w4=s19^w6
  - w3=s18^w5, w2=s17^w4, w1=s16^w3, w0=s15^w2
- A step does s <= {s[21:0], w7}. The LFSR steps only in WARMUP and on a grant; otherwise it holds.
- Reset (async, immediate):
  - state = SEED, s = 0
  - rnd_data = 8'hFF, rnd_vld = 0, rng_ready = 0
  - round-robin pointer favours req[0]
  - warm-up counter = 0
- SEED (1 cycle):
  - s <= seed. A seed of 0 is replaced by 23'h1 (all-zero lockup guard).
  - Next state is WARMUP if WARMUP>0, else SERVE.
- WARMUP: one step per cycle for exactly WARMUP cycles, words discarded, no rnd_vld; then SERVE.
- SERVE:
  - rng_ready = 1, decoded from the state register.
  - When any req bit is set, pick the winner by round-robin: first set bit at or after ptr, wrapping.
  - Register rnd_data <= w and rnd_vld <= onehot(winner); step the LFSR; ptr <= winner+1 mod NUM_REQ.
  - No req: rnd_vld <= 0; rnd_data and s hold.
- Latency: req seen at edge N gives rnd_vld at edge N+1. A requester holding req continuously is re-eligible every cycle, subject to round-robin order.
- Throughput: one grant per cycle in total. Non-granted requests stay pending; they are never dropped.
- reseed is honoured in any state, including SEED and WARMUP:
  - Next state is SEED and the warm-up counter clears.
  - reseed beats req in the same cycle: no grant, rnd_vld <= 0.
  - ptr is preserved.
- rst asserted mid-SERVE: outputs go to reset values at once and any pulse in flight is lost.

Optional Feature:
- Macro RNG_DRAW_COUNT_EN.
- Defined:
  - Extra output draw_cnt [31:0]; increments by 1 on every grant and wraps at 2^32.
  - Cleared by rst and on SEED entry.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package rng_pkg holds:
  - LFSR_W=23, WORD_W=8, ZERO_SEED_SUB=23'h1
  - the state enum {SEED, WARMUP, SERVE}
- One sub-module, rng_lfsr23_step:
  - inputs: clk, rst, load, load_val, step
  - outputs: registered state, combinational word w
  - holds the tap equations above.
- The arbiter FSM and round-robin logic stay in the top.

Test Plan:
- NUM_REQ=4, WARMUP=0, seed=1, req=4'b0001 held after reset -> rng_ready high from 2nd cycle; rnd_vld=0001 each cycle with rnd_data 0x55,0xAA,0x55,0xAA.
- req=4'b1111 held in SERVE -> rnd_vld sequence 0001,0010,0100,1000,0001; data follows the LFSR word sequence, no gaps.
- seed=0 -> identical to the seed=1 case (first word 0x55); LFSR state is never all-zero.
- WARMUP=2, seed=1, req[2] held -> rng_ready rises 3 cycles after rst release; first rnd_vld=0100 carries 0x55 (third word); no rnd_vld during warm-up.
- reseed together with req=4'b0010 in SERVE with seed=1 (WARMUP=0) -> no rnd_vld that cycle; rng_ready low 1 cycle; next grant data 0x55; ptr order continues from before reseed.
- rst asserted between edges while rnd_vld is high -> rnd_vld=0, rnd_data=0xFF, rng_ready=0 immediately; draw_cnt=0 when RNG_DRAW_COUNT_EN is defined.
